mem_arbiter: RTL and testbench

- Sequences and shares the single-port test memory between two requesters.
  - Port 0: SLC-3 CPU memory interface.
  - Port 1: debug/loader port, used for program preload and switch-driven memory inspection.
- Converts a req/ack handshake into correctly timed rden/wren pulses.
- Waits out the memory's fixed read latency, then returns registered read data.
- Sits between slc3 and test_memory in the test top.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester handshake and memory-side bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [15:0]       addr0;
  logic [15:0]       addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_readout;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_readout,
    output ack, rdata, busy, mem_addr, mem_data, mem_rden, mem_wren
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_readout,
    input  ack, rdata, busy, mem_addr, mem_data, mem_rden, mem_wren
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin grant selection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  assign gnt_valid_o = |req_i;

  // On a tie the port that did not win last time is favoured.
  always_comb begin
    gnt_idx_o = PORT_CPU;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_idx_o = PORT_DBG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-port fixed-latency memory between the CPU
//               and a debug/loader port using a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_arbiter_if.slave  bus
);

  if (READ_LAT < 1 || READ_LAT > 7) begin : g_lat_check
    $fatal(1, "mem_arbiter: READ_LAT must be in 1..7");
  end

  if (ADDR_W < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.addr0[15:ADDR_W], bus.addr1[15:ADDR_W]};
  end

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_grant_q;
  logic              idx_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              rden_q;
  logic              wren_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  rr_arbiter2 u_rr (
    .req_i        (bus.req),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  always_comb begin
    we_d   = bus.we[gnt_idx];
    addr_d = gnt_idx ? bus.addr1[ADDR_W-1:0] : bus.addr0[ADDR_W-1:0];
    data_d = gnt_idx ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_DBG;
      idx_q        <= PORT_CPU;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
    end else begin
      rden_q <= 1'b0;
      wren_q <= 1'b0;
      ack_q  <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            idx_q        <= gnt_idx;
            last_grant_q <= gnt_idx;
            we_q         <= we_d;
            mem_addr_q   <= addr_d;
            mem_data_q   <= data_d;
            // Enables are registered so they are high during ACCESS only.
            wren_q       <= we_d;
            rden_q       <= ~we_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            ack_q[idx_q] <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q   <= CNT_W'(READ_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q      <= bus.mem_readout;
            ack_q[idx_q] <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_rden = rden_q;
  assign bus.mem_wren = wren_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (READ_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic Clk;
  logic rst1;
  logic rst3;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b1 ();
  mem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b3 ();

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .READ_LAT(1)) u_dut1 (
    .Clk   (Clk),
    .Reset (rst1),
    .bus   (b1)
  );

  mem_arbiter #(.ADDR_W(10), .DATA_W(16), .READ_LAT(3)) u_dut3 (
    .Clk   (Clk),
    .Reset (rst3),
    .bus   (b3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory models: data appears READ_LAT cycles after the rden cycle, filler otherwise.
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem3 [0:1023];
  logic [15:0] p1;
  logic [15:0] p3a, p3b, p3c;

  always @(posedge Clk) begin
    if (b1.mem_wren) mem1[b1.mem_addr] <= b1.mem_data;
    p1 <= b1.mem_rden ? mem1[b1.mem_addr] : 16'hDEAD;
    if (b3.mem_wren) mem3[b3.mem_addr] <= b3.mem_data;
    p3a <= b3.mem_rden ? mem3[b3.mem_addr] : 16'hDEAD;
    p3b <= p3a;
    p3c <= p3b;
  end

  assign b1.mem_readout = p1;
  assign b3.mem_readout = p3c;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack1(output logic [1:0] got);
    got = 2'b00;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (b1.ack != 2'b00) begin
        got = b1.ack;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] got;
    logic [1:0] exp_ack;
    n_tests = 0;
    n_fail  = 0;

    mem1[1]    <= 16'h1111;
    mem1[2]    <= 16'h2222;
    mem3[32]   <= 16'h5A5A;

    b1.req = 2'b00; b1.we = 2'b00; b1.addr0 = '0; b1.addr1 = '0;
    b1.wdata0 = '0; b1.wdata1 = '0;
    b3.req = 2'b00; b3.we = 2'b00; b3.addr0 = '0; b3.addr1 = '0;
    b3.wdata0 = '0; b3.wdata1 = '0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    tick(); tick();

    chk("rst_ack",   b1.ack,      2'b00);
    chk("rst_rdata", b1.rdata,    16'h0);
    chk("rst_busy",  b1.busy,     1'b0);
    chk("rst_addr",  b1.mem_addr, 10'h0);
    chk("rst_data",  b1.mem_data, 16'h0);
    chk("rst_rden",  b1.mem_rden, 1'b0);
    chk("rst_wren",  b1.mem_wren, 1'b0);
    rst1 = 1'b0;
    tick();

    // CPU write
    b1.req = 2'b01; b1.we = 2'b01; b1.addr0 = 16'h0010; b1.wdata0 = 16'hBEEF;
    tick();
    chk("wr_c1_wren", b1.mem_wren, 1'b1);
    chk("wr_c1_rden", b1.mem_rden, 1'b0);
    chk("wr_c1_addr", b1.mem_addr, 10'h010);
    chk("wr_c1_data", b1.mem_data, 16'hBEEF);
    chk("wr_c1_busy", b1.busy,     1'b1);
    chk("wr_c1_ack",  b1.ack,      2'b00);
    tick();
    chk("wr_c2_wren", b1.mem_wren, 1'b0);
    chk("wr_c2_ack",  b1.ack,      2'b01);
    chk("wr_c2_busy", b1.busy,     1'b1);
    b1.req = 2'b00;
    tick();
    chk("wr_c3_ack",  b1.ack,      2'b00);
    chk("wr_c3_busy", b1.busy,     1'b0);

    // CPU read back, READ_LAT=1
    b1.req = 2'b01; b1.we = 2'b00;
    tick();
    chk("rd_c1_rden", b1.mem_rden, 1'b1);
    chk("rd_c1_wren", b1.mem_wren, 1'b0);
    tick();
    chk("rd_c2_rden", b1.mem_rden, 1'b0);
    chk("rd_c2_ack",  b1.ack,      2'b00);
    tick();
    chk("rd_c3_ack",   b1.ack,   2'b01);
    chk("rd_c3_rdata", b1.rdata, 16'hBEEF);
    b1.req = 2'b00;
    tick();

    // Both ports reading continuously after reset: CPU, DBG, CPU, DBG
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    b1.req = 2'b11; b1.we = 2'b00; b1.addr0 = 16'h0001; b1.addr1 = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      wait_ack1(got);
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_ack", got, exp_ack);
      chk("rr_rdata", b1.rdata, (k % 2 == 0) ? 16'h1111 : 16'h2222);
    end
    b1.req = 2'b00;
    tick();

    // Debug write with out-of-range address wraps
    b1.req = 2'b10; b1.we = 2'b10; b1.addr1 = 16'h0405; b1.wdata1 = 16'hCAFE;
    tick();
    chk("dw_c1_addr", b1.mem_addr, 10'h005);
    chk("dw_c1_wren", b1.mem_wren, 1'b1);
    tick();
    chk("dw_c2_ack",   b1.ack,   2'b10);
    chk("dw_c2_rdata", b1.rdata, 16'h2222);
    b1.req = 2'b00;
    tick();

    // Reset during WAIT of a debug read, then reissue
    b1.req = 2'b10; b1.we = 2'b00; b1.addr1 = 16'h0002;
    tick();
    tick();
    chk("rstw_in_wait", b1.busy, 1'b1);
    rst1 = 1'b1;
    tick();
    chk("rstw_busy",  b1.busy,     1'b0);
    chk("rstw_ack",   b1.ack,      2'b00);
    chk("rstw_rdata", b1.rdata,    16'h0);
    chk("rstw_addr",  b1.mem_addr, 10'h0);
    chk("rstw_data",  b1.mem_data, 16'h0);
    chk("rstw_rden",  b1.mem_rden, 1'b0);
    rst1 = 1'b0;
    wait_ack1(got);
    chk("rstw_reissue_ack",   got,      2'b10);
    chk("rstw_reissue_rdata", b1.rdata, 16'h2222);
    b1.req = 2'b00;
    tick();

    // READ_LAT=3 build, CPU read
    rst3 = 1'b0;
    tick();
    b3.req = 2'b01; b3.we = 2'b00; b3.addr0 = 16'h0020;
    tick();
    chk("l3_c1_rden", b3.mem_rden, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("l3_wait_ack",  b3.ack,      2'b00);
      chk("l3_wait_rden", b3.mem_rden, 1'b0);
    end
    tick();
    chk("l3_c5_ack",   b3.ack,   2'b01);
    chk("l3_c5_rdata", b3.rdata, 16'h5A5A);
    chk("l3_c5_busy",  b3.busy,  1'b1);
    b3.req = 2'b00;
    tick();
    chk("l3_c6_busy", b3.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
